// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the M-extension execute front end.
// Op field layout and controller state encodings.
package mdu_ctrl_pkg;

    localparam int MDU_OP_W_BIT = 3;

    localparam logic [2:0] MDU_OP_MUL    = 3'd0;
    localparam logic [2:0] MDU_OP_MULH   = 3'd1;
    localparam logic [2:0] MDU_OP_MULHSU = 3'd2;
    localparam logic [2:0] MDU_OP_MULHU  = 3'd3;
    localparam logic [2:0] MDU_OP_DIV    = 3'd4;
    localparam logic [2:0] MDU_OP_DIVU   = 3'd5;
    localparam logic [2:0] MDU_OP_REM    = 3'd6;
    localparam logic [2:0] MDU_OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        MDU_ST_IDLE  = 3'd0,
        MDU_ST_REQ   = 3'd1,
        MDU_ST_WAIT  = 3'd2,
        MDU_ST_DONE  = 3'd3,
        MDU_ST_DRAIN = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/mdu_ctrl_prep.sv
// Operand preparation for M-ops: *W extension, divide special-case
// detection and the precomputed special result.
module mdu_prep #(
    parameter int XLEN = 64
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_a,
    output logic [XLEN-1:0] o_b,
    output logic            o_w,
    output logic            o_special,
    output logic [XLEN-1:0] o_spec_res
);
    import mdu_ctrl_pkg::*;

    logic [2:0]      w_f3;
    logic            w_div;
    logic            w_rem;
    logic            w_zext;
    logic            w_sdiv;
    logic            w_w;
    logic            w_b_zero;
    logic            w_ovf;
    logic [XLEN-1:0] w_min;
    logic [XLEN-1:0] w_raw;

    assign w_f3   = i_op[2:0];
    assign w_div  = w_f3[2];
    assign w_rem  = w_f3[1];
    assign w_zext = w_div & w_f3[0];
    assign w_sdiv = w_div & ~w_f3[0];
    // MULH* with the W bit set never reach here legally; run them full width
    assign w_w    = i_op[MDU_OP_W_BIT] & (w_div | (w_f3 == MDU_OP_MUL));

    always_comb begin
        o_a = i_rs1;
        o_b = i_rs2;
        if (w_w) begin
            o_a = {{(XLEN-32){i_rs1[31] & ~w_zext}}, i_rs1[31:0]};
            o_b = {{(XLEN-32){i_rs2[31] & ~w_zext}}, i_rs2[31:0]};
        end
    end

    assign w_min    = w_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
    assign w_b_zero = (o_b == '0);
    assign w_ovf    = w_sdiv & (o_a == w_min) & (&o_b);

    always_comb begin
        w_raw = '0;
        if (w_b_zero) begin
            w_raw = w_rem ? o_a : '1;
        end else begin
            w_raw = w_rem ? '0 : o_a;
        end
    end

    assign o_w        = w_w;
    assign o_special  = w_div & (w_b_zero | w_ovf);
    assign o_spec_res = w_w ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]}
                            : w_raw;

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage controller for the MULDIV unit: launch, wait, writeback,
// stall and flush/drain handling.
module mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ex_stall_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            mdu_en_o,
    output logic [XLEN-1:0] mdu_a_o,
    output logic [XLEN-1:0] mdu_b_o,
    output logic [3:0]      mdu_op_o,
    input  logic            mdu_ready_i,
    input  logic            mdu_valid_i,
    input  logic [XLEN-1:0] mdu_result_i
);
    import mdu_ctrl_pkg::*;

    mdu_state_t      r_state;
    mdu_state_t      w_next;
    logic            r_en;
    logic            r_w;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_res;

    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_spec_res;
    logic [XLEN-1:0] w_fix;
    logic            w_w;
    logic            w_special;
    logic            w_accept;
    logic            w_capture;

    mdu_prep #(.XLEN(XLEN)) u_prep (
        .i_op       (op_i),
        .i_rs1      (rs1_i),
        .i_rs2      (rs2_i),
        .o_a        (w_a),
        .o_b        (w_b),
        .o_w        (w_w),
        .o_special  (w_special),
        .o_spec_res (w_spec_res)
    );

    assign w_accept  = (r_state == MDU_ST_IDLE) & ex_valid_i & ~flush_i;
    assign w_capture = (r_state == MDU_ST_WAIT) & mdu_valid_i & ~flush_i;
    assign w_fix     = r_w ? {{(XLEN-32){mdu_result_i[31]}}, mdu_result_i[31:0]}
                           : mdu_result_i;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            MDU_ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? MDU_ST_DONE : MDU_ST_REQ;
                end
            end
            MDU_ST_REQ: begin
                // A flush racing the accept still leaves an op inside MULDIV
                if (flush_i) begin
                    w_next = mdu_ready_i ? MDU_ST_DRAIN : MDU_ST_IDLE;
                end else if (mdu_ready_i) begin
                    w_next = MDU_ST_WAIT;
                end
            end
            MDU_ST_WAIT: begin
                if (flush_i) begin
                    w_next = mdu_valid_i ? MDU_ST_IDLE : MDU_ST_DRAIN;
                end else if (mdu_valid_i) begin
                    w_next = MDU_ST_DONE;
                end
            end
            MDU_ST_DONE: begin
                w_next = MDU_ST_IDLE;
            end
            MDU_ST_DRAIN: begin
                if (mdu_valid_i) begin
                    w_next = MDU_ST_IDLE;
                end
            end
            default: begin
                w_next = MDU_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MDU_ST_IDLE;
            r_en    <= 1'b0;
            r_w     <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            r_en    <= (w_next == MDU_ST_REQ);
            if (w_accept) begin
                r_op <= op_i;
                r_a  <= w_a;
                r_b  <= w_b;
                r_w  <= w_w;
                if (w_special) begin
                    r_res <= w_spec_res;
                end
            end
            if (w_capture) begin
                r_res <= w_fix;
            end
        end
    end

    assign ex_stall_o = rst & (w_accept
                      | (r_state == MDU_ST_REQ)
                      | (r_state == MDU_ST_WAIT)
                      | ((r_state == MDU_ST_DRAIN) & ex_valid_i));
    assign wb_valid_o = (r_state == MDU_ST_DONE) & ~flush_i;
    assign wb_data_o  = r_res;
    assign mdu_en_o   = r_en;
    assign mdu_a_o    = r_a;
    assign mdu_b_o    = r_b;
    assign mdu_op_o   = r_op;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a behavioural MULDIV model and a
// writeback scoreboard.
module tb_mdu_ctrl;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ex_valid_i = 1'b0;
    logic [3:0]      op_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic            flush_i = 1'b0;
    logic            ex_stall_o;
    logic            wb_valid_o;
    logic [XLEN-1:0] wb_data_o;
    logic            mdu_en_o;
    logic [XLEN-1:0] mdu_a_o;
    logic [XLEN-1:0] mdu_b_o;
    logic [3:0]      mdu_op_o;
    logic            mdu_ready_i;
    logic            mdu_valid_i;
    logic [XLEN-1:0] mdu_result_i;

    always #5 clk = ~clk;

    mdu_ctrl #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid_i   (ex_valid_i),
        .op_i         (op_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .flush_i      (flush_i),
        .ex_stall_o   (ex_stall_o),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .mdu_en_o     (mdu_en_o),
        .mdu_a_o      (mdu_a_o),
        .mdu_b_o      (mdu_b_o),
        .mdu_op_o     (mdu_op_o),
        .mdu_ready_i  (mdu_ready_i),
        .mdu_valid_i  (mdu_valid_i),
        .mdu_result_i (mdu_result_i)
    );

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int wb_cyc = 0;
    int en_cnt = 0;
    logic [XLEN-1:0] exp_q[$];

    // MULDIV model: ready on the 2nd request cycle, valid 4 cycles after accept
    int              m_rc;
    int              m_cnt;
    logic            m_busy;
    logic [XLEN-1:0] m_res;
    logic [XLEN-1:0] m_a;
    logic            m_force = 1'b0;
    logic [XLEN-1:0] m_force_val = '0;

    assign mdu_ready_i  = mdu_en_o && (m_rc == 1);
    assign mdu_valid_i  = m_busy && (m_cnt == 3);
    assign mdu_result_i = m_res;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_rc   <= 0;
            m_cnt  <= 0;
            m_busy <= 1'b0;
            m_res  <= '0;
            m_a    <= '0;
        end else begin
            if (mdu_en_o && !mdu_ready_i) m_rc <= m_rc + 1;
            else m_rc <= 0;
            if (mdu_en_o && mdu_ready_i) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_a    <= mdu_a_o;
                m_res  <= m_force ? m_force_val : mdu_a_o * mdu_b_o;
            end else if (mdu_valid_i) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [XLEN-1:0] exp_v;
        logic            have;
        if (mdu_en_o) en_cnt++;
        if (rst && wb_valid_o) begin
            wb_cyc = cyc;
            have   = (exp_q.size() != 0);
            exp_v  = have ? exp_q.pop_front() : '0;
            n_assert++;
            assert (have && (wb_data_o === exp_v)) else begin
                n_fail++;
                $error("FAIL wb_data: observed %h expected %h queued=%0d",
                       wb_data_o, exp_v, have);
            end
        end
    end

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                         input int lat, input string tag);
        int k;
        int t0;
        @(negedge clk);
        ex_valid_i = 1'b1;
        op_i  = op;
        rs1_i = a;
        rs2_i = b;
        exp_q.push_back(exp);
        wb_cyc = -100;
        #1;
        t0 = cyc;
        k  = 0;
        while (ex_stall_o && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, " stall_cycles"}, 64'(k), 64'(lat));
        check({tag, " wb_latency"}, 64'(wb_cyc - t0), 64'(lat));
        @(negedge clk);
        ex_valid_i = 1'b0;
    endtask

    initial begin
        int en0;
        int k;

        rst = 1'b0;
        ex_valid_i = 1'b1;
        op_i  = 4'b0100;
        rs1_i = 64'd100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst wb_valid", 64'(wb_valid_o), 64'd0);
        check("rst wb_data", wb_data_o, 64'd0);
        check("rst mdu_en", 64'(mdu_en_o), 64'd0);
        check("rst mdu_a", mdu_a_o, 64'd0);
        check("rst mdu_b", mdu_b_o, 64'd0);
        check("rst mdu_op", 64'(mdu_op_o), 64'd0);
        check("rst stall", 64'(ex_stall_o), 64'd0);
        ex_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("idle stall", 64'(ex_stall_o), 64'd0);

        en0 = en_cnt;
        issue(4'b0100, 64'd100, 64'd0, '1, 1, "div0");
        issue(4'b1100, 64'h8000_0000, 64'hFFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
        issue(4'b1110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, "remw_ovf");
        issue(4'b0100, 64'h8000_0000_0000_0000, '1,
              64'h8000_0000_0000_0000, 1, "div_ovf");
        issue(4'b0110, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf");
        issue(4'b0110, -64'sd7, 64'd0, -64'sd7, 1, "rem0");
        issue(4'b1111, 64'hFFFF_FFF0, 64'hFFFF_FFFF_0000_0000,
              64'hFFFF_FFFF_FFFF_FFF0, 1, "remuw0");
        issue(4'b1101, 64'd5, 64'h1_0000_0000, '1, 1, "divuw0");
        check("special no mdu_en", 64'(en_cnt - en0), 64'd0);

        issue(4'b0000, 64'd3, 64'd5, 64'd15, 7, "mul");
        check("mul operand a", m_a, 64'd3);

        m_force = 1'b1;
        m_force_val = 64'h0000_0000_8000_0001;
        issue(4'b1000, 64'h1_8000_0003, 64'd1,
              64'hFFFF_FFFF_8000_0001, 7, "mulw");
        check("mulw operand a", m_a, 64'hFFFF_FFFF_8000_0003);
        m_force = 1'b0;

        issue(4'b1011, 64'h1_8000_0000, 64'd1, 64'h1_8000_0000, 7, "mulhu_w");

        // flush while DONE: writeback suppressed
        @(negedge clk);
        ex_valid_i = 1'b1;
        op_i  = 4'b0100;
        rs1_i = 64'd9;
        rs2_i = 64'd0;
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("done flush wb_valid", 64'(wb_valid_o), 64'd0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        ex_valid_i = 1'b0;

        // flush while REQ: request withdrawn
        @(negedge clk);
        ex_valid_i = 1'b1;
        op_i  = 4'b0000;
        rs1_i = 64'd2;
        rs2_i = 64'd2;
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        check("req mdu_en", 64'(mdu_en_o), 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        ex_valid_i = 1'b0;
        @(negedge clk);
        check("req flush mdu_en", 64'(mdu_en_o), 64'd0);
        check("req flush stall", 64'(ex_stall_o), 64'd0);

        // flush while WAIT, then a new op queued behind the drain
        @(negedge clk);
        ex_valid_i = 1'b1;
        op_i  = 4'b0000;
        rs1_i = 64'd6;
        rs2_i = 64'd7;
        #1;
        k = 0;
        while (!(mdu_en_o && mdu_ready_i) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain handshake seen", 64'(k < 50), 64'd1);
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        rs1_i = 64'd9;
        rs2_i = 64'd11;
        exp_q.push_back(64'd99);
        @(negedge clk);
        check("drain stall", 64'(ex_stall_o), 64'd1);
        check("drain mdu_en", 64'(mdu_en_o), 64'd0);
        #1;
        k = 0;
        while (ex_stall_o && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain new op done", 64'(k < 50), 64'd1);
        @(negedge clk);
        ex_valid_i = 1'b0;
        check("drain new operand a", m_a, 64'd9);

        repeat (4) @(negedge clk);
        check("scoreboard empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Execute-stage front end for the M-extension unit. It sits between the ID/EX pipeline register and `MULDIV`, and owns everything around the arithmetic itself:
- decodes the M-op, prepares RV64 `*W` operands and resolves RISC-V divide special cases without using the unit;
- drives the `mul_en`/`ready`/`valid` handshake into `MULDIV`;
- stalls the pipeline until a result is registered for writeback;
- handles flushes, including draining an in-flight operation.

## Interface
Parameters:
- `XLEN`, 64: register width; matches `` `RegBus ``.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `ex_valid_i`  in  1  EX holds a valid M-op.
- `op_i`  in  4  `[2:0]` = funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU); `[3]` = W variant.
- `rs1_i`, `rs2_i`  in  XLEN  source operands.
- `flush_i`  in  1  kill the current EX instruction.
- `ex_stall_o`  out  1  hold IF/ID/EX.
- `wb_valid_o`  out  1  result valid (one-cycle pulse).
- `wb_data_o`  out  XLEN  result.
- `mdu_en_o`  out  1  request to `MULDIV` (`mul_en_i`).
- `mdu_a_o`, `mdu_b_o`  out  XLEN  operands to `MULDIV`.
- `mdu_op_o`  out  4  registered `op_i`.
- `mdu_ready_i`  in  1  `MULDIV` accepts the request.
- `mdu_valid_i`  in  1  `mdu_result_i` is valid.
- `mdu_result_i`  in  XLEN  raw `MULDIV` result.

## Operation
States: IDLE, REQ, WAIT, DONE, DRAIN.

- **IDLE.** When `ex_valid_i & ~flush_i`, register op, prepared operands and the special-case flag.
  - Special case → DONE with the precomputed result.
  - Otherwise → REQ.
- **REQ.** `mdu_en_o = 1`; operands held stable. `mdu_ready_i` → WAIT.
- **WAIT.** `mdu_valid_i` → capture result (W fixup applied) → DONE.
- **DONE.** `wb_valid_o = 1` for exactly one cycle → IDLE. Never relaunches, even though `ex_valid_i` is still high for the same instruction.
- **DRAIN.** Wait for `mdu_valid_i`, discard the result → IDLE.

Flush:
- `flush_i` in REQ → IDLE; `mdu_en_o` drops the next cycle.
- `flush_i` in WAIT → DRAIN.
- `flush_i` in DONE → IDLE, and `wb_valid_o` is forced 0 that cycle.
- `flush_i` in DRAIN → no effect.
- `flush_i` in IDLE → no capture.

Stall:
- `ex_stall_o = (IDLE & ex_valid_i & ~flush_i) | REQ | WAIT | (DRAIN & ex_valid_i)`.
- Low in DONE, so the pipeline advances at the end of DONE.

W operand preparation (`op_i[3]=1`):
- Signed ops (MUL, DIV, REM) sign-extend `[31:0]`.
- DIVU and REMU zero-extend `[31:0]`.
- The result is sign-extended from bit 31.
- MULH*, MULHSU and MULHU with W set are illegal upstream and are treated as non-W.

Special cases, resolved in-block (no `MULDIV` request). Width is 32 bits for W ops, XLEN otherwise:
- Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
- Signed overflow (dividend = most-negative, divisor = −1): DIV → dividend; REM → 0.
- W results are sign-extended as above.

## Timing
Reset (`rst=0` at a clock edge):
- state IDLE.
- `wb_valid_o=0`, `wb_data_o=0`, `mdu_en_o=0`.
- `mdu_a_o`, `mdu_b_o`, `mdu_op_o` all 0.
- `ex_stall_o=0` while `ex_valid_i=0`.
- Reset mid-operation abandons `MULDIV` without draining; `MULDIV` is reset on the same `rst`.

Latency, with the accept cycle = 0:
- Special case: DONE in cycle 1.
- Normal op: REQ in cycle 1. If `mdu_ready_i` is high in cycle 1, WAIT is cycle 2. If `mdu_valid_i` is high in WAIT cycle k, DONE is cycle k+1. Minimum latency is 3 cycles.

Handshake:
- `mdu_valid_i` is sampled only in WAIT and DRAIN; it is ignored elsewhere.
- `mdu_en_o` is registered and stays high in REQ until `mdu_ready_i`.
- `mdu_en_o` is never asserted in IDLE, WAIT, DONE or DRAIN.

## Structure
- Op encodings (funct3 values, W bit index) and state encodings go in `defines.v` as `` `MDU_OP_* `` and `` `MDU_ST_* ``.
- One combinational sub-module, `mdu_prep`: W operand extension, special-case detect, precomputed special result. Target ~60 lines.
- `mdu_ctrl` holds the FSM and registers, ~150 lines.

## Test plan
- Reset: hold `rst=0` 3 cycles with `ex_valid_i=1` → all outputs 0, state IDLE, no `mdu_en_o`.
- DIV with `rs1=100`, `rs2=0` → `wb_valid_o` in cycle 1, `wb_data_o=0xFFFF_FFFF_FFFF_FFFF`, `mdu_en_o` never high.
- DIVW with `rs1=0x8000_0000`, `rs2=0xFFFF_FFFF` → cycle 1, `wb_data_o=0xFFFF_FFFF_8000_0000`. The same operands as REMW → 0.
- MUL 3×5 with a model `MULDIV` (ready after 2 cycles, valid after 4) → stall held; `wb_data_o=15` for a single cycle.
- MULW with result `0x0000_0000_8000_0001` returned by the model → `wb_data_o=0xFFFF_FFFF_8000_0001`.
- Flush in WAIT, then a new MUL on the next cycle → DRAIN; the stale result is discarded; the new op waits for IDLE and yields its own result only.
